// File: rtl/rv32_mem_arbiter_if.sv
// Core-side request/response ports plus the shared memory bus, seen from the arbiter
// (slave) and from the requesters/memory around it (master).
interface rv32_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              instr_req_valid;
  logic [ADDR_W-1:0] instr_req_addr;
  logic              instr_done;
  logic [DATA_W-1:0] instr_rdata;

  logic              data_req_valid;
  logic              data_req_we;
  logic [ADDR_W-1:0] data_req_addr;
  logic [DATA_W-1:0] data_req_wdata;
  logic [BE_W-1:0]   data_req_be;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  instr_req_valid, instr_req_addr,
    output instr_done, instr_rdata,
    input  data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_req_be,
    output data_done, data_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output instr_req_valid, instr_req_addr,
    input  instr_done, instr_rdata,
    output data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_req_be,
    input  data_done, data_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data accesses.
// Data wins ties; a grant streak counter lets fetch through after MAX_DATA_BURST data grants.
module rv32_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                resetn,
  rv32_mem_arbiter_if.slave   bus
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;
  localparam logic [STREAK_W-1:0] BURST_LIM  = STREAK_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner_data;
  logic [STREAK_W-1:0]   r_streak;
  mem_req_t              r_req;
  mem_req_t              w_req_sel;
  logic                  r_req_valid;
  logic                  r_instr_done;
  logic                  r_data_done;
  logic [DATA_W-1:0]     r_instr_rdata;
  logic [DATA_W-1:0]     r_data_rdata;
  logic                  w_grant_data;
  logic                  w_grant_instr;

  // Data wins unless fetch has already waited out a full data burst
  assign w_grant_data  = bus.data_req_valid && (!bus.instr_req_valid || (r_streak != BURST_LIM));
  assign w_grant_instr = bus.instr_req_valid && !w_grant_data;

  always_comb begin
    w_req_sel      = '0;
    w_req_sel.addr = bus.instr_req_addr;
    if (w_grant_data) begin
      w_req_sel.we    = bus.data_req_we;
      w_req_sel.addr  = bus.data_req_addr;
      w_req_sel.wdata = bus.data_req_wdata;
      w_req_sel.be    = bus.data_req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_data || w_grant_instr) w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.mem_req_ready)             w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid)            w_state_nxt = S_DONE;
      S_DONE:                                     w_state_nxt = S_IDLE;
      default:                                    w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, streak tracking and response capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner_data  <= 1'b0;
      r_streak      <= '0;
      r_req         <= '0;
      r_req_valid   <= 1'b0;
      r_instr_done  <= 1'b0;
      r_data_done   <= 1'b0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_instr_done <= 1'b0;
      r_data_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_data || w_grant_instr) begin
            r_owner_data <= w_grant_data;
            r_req        <= w_req_sel;
            r_req_valid  <= 1'b1;
            if (w_grant_data && bus.instr_req_valid)
              r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + STREAK_W'(1);
            else
              r_streak <= '0;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) r_req_valid <= 1'b0;
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (r_owner_data) begin
              r_data_done <= 1'b1;
              if (!r_req.we) r_data_rdata <= bus.mem_resp_data;
            end else begin
              r_instr_done  <= 1'b1;
              r_instr_rdata <= bus.mem_resp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_we    = r_req.we;
  assign bus.mem_req_addr  = r_req.addr;
  assign bus.mem_req_wdata = r_req.wdata;
  assign bus.mem_req_be    = r_req.be;
  assign bus.instr_done    = r_instr_done;
  assign bus.instr_rdata   = r_instr_rdata;
  assign bus.data_done     = r_data_done;
  assign bus.data_rdata    = r_data_rdata;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed and randomized checks of rv32_mem_arbiter against a memory responder
// and a priority/streak reference model kept in the bench.
module tb_rv32_mem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rv32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  rv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  // Memory responder configuration
  int          cfg_rdy_wait = 0;
  int          cfg_resp_lat = 1;
  bit          cfg_rand     = 1'b0;
  bit          ovr_en       = 1'b0;
  logic [31:0] ovr_data     = 32'h0;
  bit          force_resp   = 1'b0;

  // Last bus request accepted by the memory
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory model: stalls ready, then answers after a latency; drives on negedge
  int          ph = 0;
  int          cnt = 0;
  int          rw = 0;
  int          rl = 1;
  always @(negedge clk) begin
    bus_if.mem_req_ready  = 1'b0;
    bus_if.mem_resp_valid = 1'b0;
    bus_if.mem_resp_data  = 32'h0;
    if (!resetn) begin
      ph = 0;
    end else begin
      if (ph == 0 && bus_if.mem_req_valid) begin
        ph  = 1;
        cnt = 0;
        rw  = cfg_rand ? int'($urandom_range(3, 0)) : cfg_rdy_wait;
        rl  = cfg_rand ? int'($urandom_range(3, 1)) : cfg_resp_lat;
      end
      if (ph == 1) begin
        if (cnt == rw) begin
          bus_if.mem_req_ready = 1'b1;
          acc_we    = bus_if.mem_req_we;
          acc_addr  = bus_if.mem_req_addr;
          acc_wdata = bus_if.mem_req_wdata;
          acc_be    = bus_if.mem_req_be;
          ph  = 2;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (ph == 2) begin
        cnt++;
        if (cnt == rl) begin
          bus_if.mem_resp_valid = 1'b1;
          bus_if.mem_resp_data  = ovr_en ? ovr_data : rd_data(acc_addr);
          ph = 0;
        end
      end
      if (force_resp) begin
        bus_if.mem_resp_valid = 1'b1;
        bus_if.mem_resp_data  = 32'hBAD0BAD0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output bit got_i, output bit got_d, output int cyc);
    got_i = 1'b0;
    got_d = 1'b0;
    cyc   = 0;
    while (!got_i && !got_d && cyc < 60) begin
      tick();
      cyc++;
      got_i = bus_if.instr_done;
      got_d = bus_if.data_done;
    end
    check("done_seen", 32'(got_i | got_d), 32'd1);
  endtask

  task automatic check_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check(tag, 32'({bus_if.instr_done, bus_if.data_done}), 32'd0);
    end
  endtask

  initial begin
    bit          gi, gd;
    int          cyc;
    bit          exp_burst [10];
    bit          pend_i, pend_d, exp_d;
    logic [31:0] ia, da, dwd, exp_ir, exp_dr;
    logic        dwe;
    logic [3:0]  dbe;
    int          streak;

    bus_if.instr_req_valid = 1'b0;
    bus_if.instr_req_addr  = 32'h0;
    bus_if.data_req_valid  = 1'b0;
    bus_if.data_req_we     = 1'b0;
    bus_if.data_req_addr   = 32'h0;
    bus_if.data_req_wdata  = 32'h0;
    bus_if.data_req_be     = 4'h0;

    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_mem_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
    check("rst_mem_req_addr", bus_if.mem_req_addr, 32'h0);
    check("rst_mem_req_wdata", bus_if.mem_req_wdata, 32'h0);
    check("rst_mem_req_we_be", 32'({bus_if.mem_req_we, bus_if.mem_req_be}), 32'd0);
    check("rst_dones", 32'({bus_if.instr_done, bus_if.data_done}), 32'd0);
    check("rst_instr_rdata", bus_if.instr_rdata, 32'h0);
    check("rst_data_rdata", bus_if.data_rdata, 32'h0);

    // Single fetch, minimum latency
    ovr_en = 1'b1;
    ovr_data = 32'hDEADBEEF;
    cfg_rdy_wait = 0;
    cfg_resp_lat = 1;
    bus_if.instr_req_valid = 1'b1;
    bus_if.instr_req_addr  = 32'h100;
    wait_done(gi, gd, cyc);
    bus_if.instr_req_valid = 1'b0;
    check("fetch_latency", 32'(cyc), 32'd3);
    check("fetch_owner", 32'({gi, gd}), 32'b10);
    check("fetch_rdata", bus_if.instr_rdata, 32'hDEADBEEF);
    check("fetch_bus_addr", acc_addr, 32'h100);
    tick();
    check("fetch_done_pulse", 32'(bus_if.instr_done), 32'd0);
    ovr_en = 1'b0;

    // Both requesters held: burst limit alternation
    exp_burst = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    cfg_rand = 1'b1;
    bus_if.data_req_valid = 1'b1;
    bus_if.data_req_we    = 1'b0;
    bus_if.data_req_addr  = 32'h200;
    bus_if.instr_req_valid = 1'b1;
    bus_if.instr_req_addr  = 32'h300;
    for (int k = 0; k < 10; k++) begin
      wait_done(gi, gd, cyc);
      check($sformatf("burst_%0d_is_data", k), 32'(gd), 32'(exp_burst[k]));
    end
    bus_if.data_req_valid  = 1'b0;
    bus_if.instr_req_valid = 1'b0;
    check("burst_data_rdata", bus_if.data_rdata, rd_data(32'h200));
    check("burst_instr_rdata", bus_if.instr_rdata, rd_data(32'h300));
    tick();

    // Write with ready stalled for five cycles
    cfg_rand = 1'b0;
    cfg_rdy_wait = 5;
    cfg_resp_lat = 2;
    bus_if.data_req_valid = 1'b1;
    bus_if.data_req_we    = 1'b1;
    bus_if.data_req_addr  = 32'h20;
    bus_if.data_req_wdata = 32'h12345678;
    bus_if.data_req_be    = 4'b0011;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(bus_if.mem_req_valid), 32'd1);
      check("stall_addr", bus_if.mem_req_addr, 32'h20);
      check("stall_wdata", bus_if.mem_req_wdata, 32'h12345678);
      check("stall_we_be", 32'({bus_if.mem_req_we, bus_if.mem_req_be}), 32'h13);
      tick();
    end
    wait_done(gi, gd, cyc);
    bus_if.data_req_valid = 1'b0;
    bus_if.data_req_we    = 1'b0;
    check("write_owner", 32'({gi, gd}), 32'b01);
    check("write_keeps_rdata", bus_if.data_rdata, rd_data(32'h200));
    tick();

    // Data requester drops valid mid-transaction
    cfg_rdy_wait = 0;
    cfg_resp_lat = 2;
    bus_if.data_req_valid = 1'b1;
    bus_if.data_req_addr  = 32'h44;
    tick();
    bus_if.data_req_valid = 1'b0;
    wait_done(gi, gd, cyc);
    check("drop_owner", 32'({gi, gd}), 32'b01);
    check("drop_rdata", bus_if.data_rdata, rd_data(32'h44));
    tick();

    // Stray response while idle
    force_resp = 1'b1;
    tick();
    force_resp = 1'b0;
    check_quiet("idle_resp_no_done", 4);
    check("idle_resp_data_rdata", bus_if.data_rdata, rd_data(32'h44));
    check("idle_resp_instr_rdata", bus_if.instr_rdata, rd_data(32'h300));

    // Reset while waiting for a response, then a late response
    cfg_resp_lat = 6;
    bus_if.instr_req_valid = 1'b1;
    bus_if.instr_req_addr  = 32'h500;
    tick();
    tick();
    check("wait_valid_low", 32'(bus_if.mem_req_valid), 32'd0);
    resetn = 1'b0;
    bus_if.instr_req_valid = 1'b0;
    tick();
    check("abort_addr", bus_if.mem_req_addr, 32'h0);
    check("abort_instr_rdata", bus_if.instr_rdata, 32'h0);
    check("abort_data_rdata", bus_if.data_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    force_resp = 1'b1;
    tick();
    force_resp = 1'b0;
    check_quiet("late_resp_no_done", 4);
    check("late_resp_instr_rdata", bus_if.instr_rdata, 32'h0);
    check("late_resp_valid", 32'(bus_if.mem_req_valid), 32'd0);

    // Randomized traffic against the priority/streak reference model
    cfg_rand = 1'b1;
    streak = 0;
    exp_ir = 32'h0;
    exp_dr = 32'h0;
    pend_i = 1'b0;
    pend_d = 1'b0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; dwe = 1'b0; dbe = 4'h0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_i && ($urandom_range(3, 0) != 0)) begin
        pend_i = 1'b1;
        ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_d && ($urandom_range(3, 0) != 0 || !pend_i)) begin
        pend_d = 1'b1;
        da  = $urandom & 32'hFFFF_FFFC;
        dwe = 1'($urandom_range(1, 0));
        dwd = $urandom;
        dbe = 4'($urandom_range(15, 1));
      end
      bus_if.instr_req_valid = pend_i;
      bus_if.instr_req_addr  = ia;
      bus_if.data_req_valid  = pend_d;
      bus_if.data_req_addr   = da;
      bus_if.data_req_we     = dwe;
      bus_if.data_req_wdata  = dwd;
      bus_if.data_req_be     = dbe;

      exp_d = pend_d && (!pend_i || streak != int'(MAXB));
      if (exp_d && pend_i) streak = (streak == 15) ? 15 : streak + 1;
      else                 streak = 0;

      wait_done(gi, gd, cyc);
      check("rnd_owner_is_data", 32'(gd), 32'(exp_d));
      check("rnd_single_done", 32'(gi & gd), 32'd0);
      if (exp_d) begin
        check("rnd_data_addr", acc_addr, da);
        check("rnd_data_we_be", 32'({acc_we, acc_be}), 32'({dwe, dbe}));
        if (dwe) check("rnd_data_wdata", acc_wdata, dwd);
        else     exp_dr = rd_data(da);
        pend_d = 1'b0;
      end else begin
        check("rnd_instr_addr", acc_addr, ia);
        check("rnd_instr_we", 32'(acc_we), 32'd0);
        exp_ir = rd_data(ia);
        pend_i = 1'b0;
      end
      check("rnd_data_rdata", bus_if.data_rdata, exp_dr);
      check("rnd_instr_rdata", bus_if.instr_rdata, exp_ir);
      bus_if.instr_req_valid = pend_i;
      bus_if.data_req_valid  = pend_d;
    end
    bus_if.instr_req_valid = 1'b0;
    bus_if.data_req_valid  = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
